fruta_spawner: RTL
==================

// Module: fruta_spawner
// PURPOSE
//  Parametrised fruit placer for the snake map. On request, it draws pseudo-random
//  (x,y) cells from a free-running LFSR. It rejects cells outside the map or occupied
//  by the snake, checking each candidate against the map occupancy RAM. After
//  MAX_TRIES failed draws it falls back to a deterministic raster scan for a free cell.
//  It pulses fruta_write with the chosen cell, or pulses spawn_fail if the map is full.
//  Sits between the game controller (spawn_req) and the map RAM write port.
// PARAMETERS
//  MAPA_WIDTH   40       map columns, 2..1024
//  MAPA_HEIGHT  30       map rows, 2..1024
//  LFSR_W       16       LFSR width; must be >= XW+YW (elaboration check)
//  SEED         16'hACE1 LFSR reset value; 0 is replaced by 1
//  MAX_TRIES    64       random draws before raster fallback, >= 1
//  Derived: XW=$clog2(MAPA_WIDTH), YW=$clog2(MAPA_HEIGHT), CELLS=MAPA_WIDTH*MAPA_HEIGHT
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  spawn_req     in   1   1-cycle pulse: place one fruit
//  map_rx        out  10  occupancy read column, zero-extended
//  map_ry        out  10  occupancy read row, zero-extended
//  map_occupied  in   1   occupancy of (map_rx,map_ry); synchronous, 1-cycle read latency
//  fruta_write   out  1   1-cycle pulse: fruta_xw/fruta_yw valid, write fruit to map
//  fruta_xw      out  10  fruit column, zero-extended
//  fruta_yw      out  10  fruit row, zero-extended
//  busy          out  1   high from the cycle after an accepted spawn_req until IDLE
//  spawn_fail    out  1   1-cycle pulse: no free cell exists
// BEHAVIOUR
//  Reset: all outputs 0; LFSR = SEED (or 1 if SEED==0); state IDLE; try counter 0.
//  LFSR: Galois, maximal-length taps (16-bit: 0xB400). It advances every cycle in every
//   state, so results depend on request timing.
//  Candidate: x = lfsr[XW-1:0], y = lfsr[XW+YW-1:XW], sampled in DRAW.
//  FSM:
//   IDLE  : spawn_req=1 -> DRAW, clear try counter. spawn_req is ignored in all other states.
//   DRAW  : latch candidate; try++.
//           If x>=MAPA_WIDTH or y>=MAPA_HEIGHT: if try==MAX_TRIES -> SCAN_A, else DRAW.
//           Otherwise -> ADDR.
//   ADDR  : drive map_rx/map_ry = candidate -> CHECK.
//   CHECK : sample map_occupied.
//           Free -> WRITE.
//           Occupied and try<MAX_TRIES -> DRAW.
//           Occupied and try==MAX_TRIES -> SCAN_A, with scan counter = 0 and the scan
//           cursor at the last latched candidate, clamped into range.
//   SCAN_A: drive cursor on map_rx/ry -> SCAN_C.
//   SCAN_C: free -> WRITE at cursor.
//           Occupied: increment scan counter; advance cursor in raster order (x+1; wrap
//           to x=0,y+1; (W-1,H-1) wraps to (0,0)).
//           Scan counter==CELLS -> FAIL, else SCAN_A.
//   WRITE : fruta_write=1 and fruta_xw/yw = cell for exactly this cycle -> IDLE.
//   FAIL  : spawn_fail=1 for exactly this cycle -> IDLE.
//  fruta_xw/yw hold their last written value between writes. map_rx/ry are don't-care
//   outside ADDR/SCAN_A.
//  busy = (state != IDLE).
//  Latency: minimum 4 cycles from spawn_req to fruta_write (DRAW, ADDR, CHECK, WRITE).
//   Worst case: MAX_TRIES*3 + 2*CELLS + 2 cycles.
//  Never writes an out-of-range or occupied cell; at most one write or fail per request.
//  Reset mid-operation: immediate return to IDLE; no write or fail pulse is emitted.
//  Arithmetic: all compares unsigned at XW/YW width; the scan counter is $clog2(CELLS+1) bits.
// STRUCTURE
//  fruta_pkg: state enum (IDLE, DRAW, ADDR, CHECK, SCAN_A, SCAN_C, WRITE, FAIL),
//   LFSR tap constants per width, and the 10-bit coordinate width constant.
//  Sub-module fruta_lfsr (width/taps/seed parameters, free-running, async reset).
//  FSM, try counter and scan cursor live in fruta_spawner.
// TESTING
//  T1 rst_n=0 mid-CHECK -> outputs 0 and busy=0 next edge; no fruta_write after release.
//  T2 Empty map model, 40x30, 200 spawn_req -> 200 fruta_write pulses, every x<40, y<30,
//     each within the worst-case latency, and busy low between pulses.
//  T3 Map full except (39,29) -> exactly one fruta_write with (39,29) within 3*64+2*1200+2
//     cycles; spawn_fail stays 0.
//  T4 Map fully occupied -> exactly one spawn_fail pulse, no fruta_write, return to IDLE.
//  T5 spawn_req pulsed every cycle while busy -> exactly one write per accepted request;
//     the map read model's 1-cycle latency is respected (model returns X otherwise).
//  T6 MAPA_WIDTH=5, MAPA_HEIGHT=3, empty map, 2000 spawns -> all in range, all 15 cells
//     hit at least once.

Source files
------------

// File: rtl/fruta_pkg.sv
// Shared definitions for the fruit placer: FSM states, coordinate width and
// maximal-length Galois LFSR tap masks.
package fruta_pkg;

    // Width of every coordinate port; narrower internal coordinates are zero-extended.
    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        ADDR,
        CHECK,
        SCAN_A,
        SCAN_C,
        WRITE,
        FAIL
    } fruta_state_t;

    // Right-shifting Galois tap masks giving a maximal-length sequence per width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            20:      return 32'h0009_0000;
            24:      return 32'h00D8_0000;
            32:      return 32'hA300_0000;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/fruta_lfsr.sv
// Free-running Galois LFSR; exposes only the low OUT_W bits used as a candidate cell.
module fruta_lfsr #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]   SEED  = 16'hACE1,
    parameter int                 OUT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [OUT_W-1:0] o_bits
);

    // An all-zero state would lock the LFSR, so a zero seed starts from 1 instead.
    localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_lfsr;

    // Advance one step every cycle regardless of what the consumer is doing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= INIT;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/fruta_spawner.sv
// Fruit placer: random draws checked against the occupancy RAM, with a raster
// scan fallback once the random attempts are used up.
module fruta_spawner
    import fruta_pkg::*;
#(
    parameter int                MAPA_WIDTH  = 40,
    parameter int                MAPA_HEIGHT = 30,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
    parameter int                MAX_TRIES   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spawn_req,
    output logic [COORD_W-1:0] map_rx,
    output logic [COORD_W-1:0] map_ry,
    input  logic               map_occupied,
    output logic               fruta_write,
    output logic [COORD_W-1:0] fruta_xw,
    output logic [COORD_W-1:0] fruta_yw,
    output logic               busy,
    output logic               spawn_fail
);

    localparam int XW    = $clog2(MAPA_WIDTH);
    localparam int YW    = $clog2(MAPA_HEIGHT);
    localparam int CELLS = MAPA_WIDTH * MAPA_HEIGHT;
    localparam int SW    = $clog2(CELLS + 1);
    localparam int TW    = $clog2(MAX_TRIES + 1);

    localparam logic [XW:0]    XLIM    = (XW + 1)'(MAPA_WIDTH);
    localparam logic [YW:0]    YLIM    = (YW + 1)'(MAPA_HEIGHT);
    localparam logic [XW-1:0]  XLAST   = XW'(MAPA_WIDTH - 1);
    localparam logic [YW-1:0]  YLAST   = YW'(MAPA_HEIGHT - 1);
    localparam logic [SW-1:0]  SCELLS  = SW'(CELLS);
    localparam logic [TW-1:0]  TRIES_C = TW'(MAX_TRIES);
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    if (LFSR_W < XW + YW) begin : g_lfsr_too_narrow
        $error("fruta_spawner: LFSR_W must be at least XW+YW");
    end
    if (MAX_TRIES < 1) begin : g_tries_too_small
        $error("fruta_spawner: MAX_TRIES must be at least 1");
    end

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] x);
        return ({1'b0, x} >= XLIM) ? XLAST : x;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] y);
        return ({1'b0, y} >= YLIM) ? YLAST : y;
    endfunction

    fruta_state_t   r_state, w_state_nx;
    logic [TW-1:0]  r_try, w_try_nx;
    logic [XW-1:0]  r_cx, w_cx_nx, r_sx, w_sx_nx, r_fx, w_fx_nx;
    logic [YW-1:0]  r_cy, w_cy_nx, r_sy, w_sy_nx, r_fy, w_fy_nx;
    logic [SW-1:0]  r_scnt, w_scnt_nx;

    logic [XW+YW-1:0] w_cand;
    logic [XW-1:0]    w_lx;
    logic [YW-1:0]    w_ly;
    logic             w_oor;

    fruta_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .OUT_W (XW + YW)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_bits  (w_cand)
    );

    assign w_lx  = w_cand[XW-1:0];
    assign w_ly  = w_cand[XW+YW-1:XW];
    assign w_oor = ({1'b0, w_lx} >= XLIM) || ({1'b0, w_ly} >= YLIM);

    // State, try counter, candidate, scan cursor and written-cell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_try   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_scnt  <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_try   <= w_try_nx;
            r_cx    <= w_cx_nx;
            r_cy    <= w_cy_nx;
            r_sx    <= w_sx_nx;
            r_sy    <= w_sy_nx;
            r_scnt  <= w_scnt_nx;
            r_fx    <= w_fx_nx;
            r_fy    <= w_fy_nx;
        end
    end

    // Next-state logic: random draws first, raster scan after MAX_TRIES misses.
    always_comb begin
        w_state_nx = r_state;
        w_try_nx   = r_try;
        w_cx_nx    = r_cx;
        w_cy_nx    = r_cy;
        w_sx_nx    = r_sx;
        w_sy_nx    = r_sy;
        w_scnt_nx  = r_scnt;
        w_fx_nx    = r_fx;
        w_fy_nx    = r_fy;
        case (r_state)
            IDLE: begin
                if (spawn_req) begin
                    w_state_nx = DRAW;
                    w_try_nx   = '0;
                end
            end
            DRAW: begin
                w_cx_nx  = w_lx;
                w_cy_nx  = w_ly;
                w_try_nx = r_try + 1'b1;
                if (!w_oor) begin
                    w_state_nx = ADDR;
                end else if (w_try_nx == TRIES_C) begin
                    w_state_nx = SCAN_A;
                    w_scnt_nx  = '0;
                    w_sx_nx    = clamp_x(w_lx);
                    w_sy_nx    = clamp_y(w_ly);
                end else begin
                    w_state_nx = DRAW;
                end
            end
            ADDR: begin
                w_state_nx = CHECK;
            end
            CHECK: begin
                if (!map_occupied) begin
                    w_state_nx = WRITE;
                    w_fx_nx    = r_cx;
                    w_fy_nx    = r_cy;
                end else if (r_try == TRIES_C) begin
                    w_state_nx = SCAN_A;
                    w_scnt_nx  = '0;
                    w_sx_nx    = clamp_x(r_cx);
                    w_sy_nx    = clamp_y(r_cy);
                end else begin
                    w_state_nx = DRAW;
                end
            end
            SCAN_A: begin
                w_state_nx = SCAN_C;
            end
            SCAN_C: begin
                if (!map_occupied) begin
                    w_state_nx = WRITE;
                    w_fx_nx    = r_sx;
                    w_fy_nx    = r_sy;
                end else begin
                    w_scnt_nx = r_scnt + 1'b1;
                    if (r_sx == XLAST) begin
                        w_sx_nx = '0;
                        w_sy_nx = (r_sy == YLAST) ? '0 : r_sy + 1'b1;
                    end else begin
                        w_sx_nx = r_sx + 1'b1;
                    end
                    w_state_nx = (w_scnt_nx == SCELLS) ? FAIL : SCAN_A;
                end
            end
            WRITE:   w_state_nx = IDLE;
            FAIL:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // The RAM address is the scan cursor in SCAN_A and the random candidate otherwise.
    assign map_rx      = COORD_W'((r_state == SCAN_A) ? r_sx : r_cx);
    assign map_ry      = COORD_W'((r_state == SCAN_A) ? r_sy : r_cy);
    assign fruta_write = (r_state == WRITE);
    assign fruta_xw    = COORD_W'(r_fx);
    assign fruta_yw    = COORD_W'(r_fy);
    assign spawn_fail  = (r_state == FAIL);
    assign busy        = (r_state != IDLE);

endmodule
